// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon sponge controller: precomputed 320-bit
// initial states for hash and XOF, FSM state encoding and default round counts.
package ascon_pkg;

  localparam logic [319:0] IV_HASH = {
    64'hee9398aadb67f03d, 64'h8bb21831c60f1002, 64'hb48a92db98d5da62,
    64'h43189921b8f8e3e8, 64'h348fa5c9d525e140
  };

  localparam logic [319:0] IV_XOF = {
    64'hb57e273b814cd416, 64'h2b51042562ae2420, 64'h66a3a7768ddf2218,
    64'h5aad0a7a8153650c, 64'h4f3e0e32539493b6
  };

  localparam int ROUNDS_PA = 12;
  localparam int ROUNDS_PB = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_ABS_WAIT = 3'd2,
    ST_ABS_PERM = 3'd3,
    ST_SQ_OUT   = 3'd4,
    ST_SQ_PERM  = 3'd5,
    ST_DONE     = 3'd6
  } sponge_state_e;

  function automatic logic [319:0] select_iv(input logic xof);
    return xof ? IV_XOF : IV_HASH;
  endfunction

endpackage

// File: rtl/ascon_sponge_ctrl.sv
// Ascon sponge sequencer: absorbs padded blocks, squeezes output blocks and
// drives an external permutation core. Define ASCON_SPONGE_EARLY_STOP_EN to add sq_stop.
module ascon_sponge_ctrl
  import ascon_pkg::*;
#(
  parameter int R  = 64,
  parameter int A  = ROUNDS_PA,
  parameter int B  = ROUNDS_PB,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [CW-1:0] msg_blocks,
  input  logic [CW-1:0] out_blocks,
  input  logic          abort,
  input  logic          msg_valid,
  input  logic [R-1:0]  msg_data,
  output logic          msg_ready,
  output logic          sq_valid,
  output logic [R-1:0]  sq_data,
  input  logic          sq_ready,
`ifdef ASCON_SPONGE_EARLY_STOP_EN
  input  logic          sq_stop,
`endif
  output logic          perm_start,
  output logic [4:0]    perm_rounds,
  output logic [319:0]  perm_in,
  input  logic [319:0]  perm_out,
  input  logic          perm_ready,
  output logic          perm_abort,
  output logic          busy,
  output logic          done,
  output logic [2:0]    state,
  output logic [CW-1:0] block_ctr
);

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [4:0]    ROUNDS_A = 5'(A);
  localparam logic [4:0]    ROUNDS_B = 5'(B);

  sponge_state_e r_state;
  sponge_state_e w_next;
  logic [319:0]  r_s;
  logic [CW-1:0] r_blk_ctr;
  logic [CW-1:0] r_msg_blocks;
  logic [CW-1:0] r_out_blocks;
  logic [CW-1:0] w_ctr_inc;
  logic          r_mode;
  logic          r_perm_start;
  logic          w_active_abort;
  logic          w_msg_fire;
  logic          w_sq_fire;
  logic          w_perm_fire;
  logic          w_last_msg;
  logic          w_last_sq;

  assign w_ctr_inc      = r_blk_ctr + ONE;
  assign w_last_msg     = (w_ctr_inc == r_msg_blocks);
  assign w_active_abort = abort && (r_state != ST_IDLE);

`ifdef ASCON_SPONGE_EARLY_STOP_EN
  assign w_last_sq = (w_ctr_inc == r_out_blocks) || sq_stop;
`else
  assign w_last_sq = (w_ctr_inc == r_out_blocks);
`endif

  // Abort overrides every handshake so nothing is consumed in the abort cycle.
  always_comb begin
    w_next      = r_state;
    w_msg_fire  = 1'b0;
    w_sq_fire   = 1'b0;
    w_perm_fire = 1'b0;
    case (r_state)
      ST_IDLE:     if (start && !abort) w_next = ST_LOAD;
      ST_LOAD:     w_next = ST_ABS_WAIT;
      ST_ABS_WAIT: if (msg_valid) begin
        w_msg_fire = 1'b1;
        w_next     = ST_ABS_PERM;
      end
      ST_ABS_PERM: if (perm_ready) begin
        w_perm_fire = 1'b1;
        w_next      = w_last_msg ? ST_SQ_OUT : ST_ABS_WAIT;
      end
      ST_SQ_OUT:   if (sq_ready) begin
        w_sq_fire = 1'b1;
        w_next    = w_last_sq ? ST_DONE : ST_SQ_PERM;
      end
      ST_SQ_PERM:  if (perm_ready) begin
        w_perm_fire = 1'b1;
        w_next      = ST_SQ_OUT;
      end
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
    if (w_active_abort) begin
      w_next      = ST_IDLE;
      w_msg_fire  = 1'b0;
      w_sq_fire   = 1'b0;
      w_perm_fire = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_s          <= '0;
      r_blk_ctr    <= '0;
      r_msg_blocks <= '0;
      r_out_blocks <= '0;
      r_mode       <= 1'b0;
      r_perm_start <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_perm_start <= w_msg_fire || (w_sq_fire && !w_last_sq);
      if (w_active_abort) begin
        r_blk_ctr <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (start && !abort) begin
            r_mode       <= mode;
            r_msg_blocks <= (msg_blocks == '0) ? ONE : msg_blocks;
            r_out_blocks <= (out_blocks == '0) ? ONE : out_blocks;
          end
          ST_LOAD: begin
            r_s       <= select_iv(r_mode);
            r_blk_ctr <= '0;
          end
          ST_ABS_WAIT: if (w_msg_fire) r_s[319 -: R] <= r_s[319 -: R] ^ msg_data;
          ST_ABS_PERM: if (w_perm_fire) begin
            r_s       <= perm_out;
            r_blk_ctr <= w_last_msg ? '0 : w_ctr_inc;
          end
          ST_SQ_PERM: if (w_perm_fire) begin
            r_s       <= perm_out;
            r_blk_ctr <= w_ctr_inc;
          end
          default: ;
        endcase
      end
    end
  end

  // perm_in mirrors S, which is frozen while a permutation is outstanding.
  assign perm_in     = r_s;
  assign perm_start  = r_perm_start;
  assign perm_rounds = ((r_state == ST_ABS_WAIT || r_state == ST_ABS_PERM) && w_last_msg)
                       ? ROUNDS_A : ROUNDS_B;
  assign perm_abort  = abort && (r_state == ST_ABS_PERM || r_state == ST_SQ_PERM);
  assign msg_ready   = (r_state == ST_ABS_WAIT) && !abort;
  assign sq_valid    = (r_state == ST_SQ_OUT) && !abort;
  assign sq_data     = r_s[319 -: R];
  assign done        = (r_state == ST_DONE) && !abort;
  assign busy        = (r_state != ST_IDLE);
  assign state       = r_state;
  assign block_ctr   = r_blk_ctr;

endmodule

// File: tb/tb_ascon_sponge_ctrl.sv
// Scoreboard bench for ascon_sponge_ctrl: jobs are expanded by a sponge-level
// reference model into expected permutation calls, squeeze words and done pulses.
module tb_ascon_sponge_ctrl;

  localparam int R  = 64;
  localparam int CW = 16;
  localparam int A  = 12;
  localparam int B  = 6;

  localparam logic [319:0] IV_HASH_REF = {
    64'hee9398aadb67f03d, 64'h8bb21831c60f1002, 64'hb48a92db98d5da62,
    64'h43189921b8f8e3e8, 64'h348fa5c9d525e140
  };
  localparam logic [319:0] IV_XOF_REF = {
    64'hb57e273b814cd416, 64'h2b51042562ae2420, 64'h66a3a7768ddf2218,
    64'h5aad0a7a8153650c, 64'h4f3e0e32539493b6
  };

  typedef struct packed {
    logic [4:0]   rounds;
    logic [319:0] din;
  } permExp_t;

  typedef struct packed {
    logic [R-1:0]  data;
    logic [CW-1:0] ctr;
  } sqExp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          mode;
  logic [CW-1:0] msg_blocks;
  logic [CW-1:0] out_blocks;
  logic          abort;
  logic          msg_valid;
  logic [R-1:0]  msg_data;
  logic          msg_ready;
  logic          sq_valid;
  logic [R-1:0]  sq_data;
  logic          sq_ready;
  logic          perm_start;
  logic [4:0]    perm_rounds;
  logic [319:0]  perm_in;
  logic [319:0]  perm_out;
  logic          perm_ready;
  logic          perm_abort;
  logic          busy;
  logic          done;
  logic [2:0]    state;
  logic [CW-1:0] block_ctr;
`ifdef ASCON_SPONGE_EARLY_STOP_EN
  logic          sqStop;
  logic          stopActive;
`endif

  permExp_t     expPerm[$];
  sqExp_t       expSq[$];
  int           expDone;
  logic [R-1:0] jobMsgs[$];
  int           testsRun;
  int           testsFailed;
  logic         holdSqLow;
  logic         echoMode;
  logic         abortWindow;

  ascon_sponge_ctrl #(.R(R), .A(A), .B(B), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .msg_blocks  (msg_blocks),
    .out_blocks  (out_blocks),
    .abort       (abort),
    .msg_valid   (msg_valid),
    .msg_data    (msg_data),
    .msg_ready   (msg_ready),
    .sq_valid    (sq_valid),
    .sq_data     (sq_data),
    .sq_ready    (sq_ready),
`ifdef ASCON_SPONGE_EARLY_STOP_EN
    .sq_stop     (sqStop),
`endif
    .perm_start  (perm_start),
    .perm_rounds (perm_rounds),
    .perm_in     (perm_in),
    .perm_out    (perm_out),
    .perm_ready  (perm_ready),
    .perm_abort  (perm_abort),
    .busy        (busy),
    .done        (done),
    .state       (state),
    .block_ctr   (block_ctr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Stand-in permutation: any fixed invertible-looking mix is enough, since the
  // controller only moves state around; echo mode returns the input unchanged.
  function automatic logic [319:0] permModel(input logic [319:0] x, input logic [4:0] rnds);
    logic [319:0] y;
    if (echoMode) return x;
    y = {x[300:0], x[319:301]};
    y[4:0] = y[4:0] ^ rnds;
    y[319:256] = y[319:256] ^ 64'h0123456789abcdef;
    return y;
  endfunction

  task automatic checkOutput(input string name, input logic [319:0] actual,
                             input logic [319:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Expand one job into the sequence of events the sponge must produce.
  task automatic buildJob(input logic m, input int nMsg, input int nOut, input int stopAt);
    logic [319:0] s;
    logic [R-1:0] md;
    permExp_t     pe;
    sqExp_t       se;
    int effMsg, effOut, effSq;
    effMsg = (nMsg == 0) ? 1 : nMsg;
    effOut = (nOut == 0) ? 1 : nOut;
    effSq  = (stopAt > 0 && stopAt < effOut) ? stopAt : effOut;
    s = m ? IV_XOF_REF : IV_HASH_REF;
    jobMsgs.delete();
    for (int i = 0; i < effMsg; i++) begin
      md = R'({$urandom, $urandom, $urandom, $urandom});
      jobMsgs.push_back(md);
      s[319 -: R] = s[319 -: R] ^ md;
      pe.rounds = (i == effMsg - 1) ? 5'(A) : 5'(B);
      pe.din = s;
      expPerm.push_back(pe);
      s = permModel(s, pe.rounds);
    end
    for (int j = 0; j < effSq; j++) begin
      se.data = s[319 -: R];
      se.ctr  = CW'(j);
      expSq.push_back(se);
      if (j < effSq - 1) begin
        pe.rounds = 5'(B);
        pe.din = s;
        expPerm.push_back(pe);
        s = permModel(s, pe.rounds);
      end
    end
    expDone++;
  endtask

  task automatic feedMsg(input logic [R-1:0] d);
    int n;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    msg_valid = 1'b1;
    msg_data = d;
    n = 0;
    #1;
    while (msg_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("msg_ready_seen", 320'(msg_ready), 320'd1);
    @(negedge clk);
    msg_valid = 1'b0;
    msg_data = R'({$urandom, $urandom});
  endtask

  task automatic startJob(input logic m, input int nMsg, input int nOut);
    @(negedge clk);
    start = 1'b1;
    mode = m;
    msg_blocks = CW'(nMsg);
    out_blocks = CW'(nOut);
    @(negedge clk);
    start = 1'b0;
    mode = 1'($urandom);
    msg_blocks = CW'($urandom_range(5, 9));
    out_blocks = CW'($urandom_range(5, 9));
  endtask

  task automatic applyStimulus(input logic m, input int nMsg, input int nOut, input int stopAt);
    int n;
    buildJob(m, nMsg, nOut, stopAt);
`ifdef ASCON_SPONGE_EARLY_STOP_EN
    stopActive = (stopAt > 0);
`endif
    startJob(m, nMsg, nOut);
    foreach (jobMsgs[i]) feedMsg(jobMsgs[i]);
    n = 0;
    while ((expDone != 0 || expSq.size() != 0 || expPerm.size() != 0 || state !== 3'd0)
           && n < 3000) begin
      @(negedge clk);
      #3;
      n++;
    end
    checkOutput("job_pending", 320'(expDone + expSq.size() + expPerm.size()), 320'd0);
    checkOutput("job_idle", 320'(state), 320'd0);
`ifdef ASCON_SPONGE_EARLY_STOP_EN
    stopActive = 1'b0;
`endif
  endtask

  task automatic waitState(input logic [2:0] st, input string name);
    int n;
    n = 0;
    #3;
    while (state !== st && n < 400) begin
      @(negedge clk);
      #3;
      n++;
    end
    checkOutput(name, 320'(state), 320'(st));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_state"}, 320'(state), 320'd0);
    checkOutput({tag, "_busy"}, 320'(busy), 320'd0);
    checkOutput({tag, "_done"}, 320'(done), 320'd0);
    checkOutput({tag, "_msg_ready"}, 320'(msg_ready), 320'd0);
    checkOutput({tag, "_sq_valid"}, 320'(sq_valid), 320'd0);
    checkOutput({tag, "_perm_start"}, 320'(perm_start), 320'd0);
    checkOutput({tag, "_perm_abort"}, 320'(perm_abort), 320'd0);
    checkOutput({tag, "_block_ctr"}, 320'(block_ctr), 320'd0);
    checkOutput({tag, "_sq_data"}, 320'(sq_data), 320'd0);
    checkOutput({tag, "_perm_in"}, perm_in, 320'd0);
  endtask

  // Permutation core model: answers each perm_start after a short random delay.
  initial begin
    logic [319:0] pin;
    logic [4:0]   prnd;
    perm_ready = 1'b0;
    perm_out = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n === 1'b1 && perm_start === 1'b1) begin
        pin = perm_in;
        prnd = perm_rounds;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        perm_out = permModel(pin, prnd);
        perm_ready = 1'b1;
        @(negedge clk);
        perm_ready = 1'b0;
      end
    end
  end

  // Squeeze consumer with random back-pressure.
  initial begin
    sq_ready = 1'b0;
`ifdef ASCON_SPONGE_EARLY_STOP_EN
    sqStop = 1'b0;
`endif
    forever begin
      @(negedge clk);
      sq_ready = holdSqLow ? 1'b0 : ($urandom_range(0, 3) != 0);
`ifdef ASCON_SPONGE_EARLY_STOP_EN
      sqStop = stopActive && (expSq.size() == 1);
`endif
    end
  end

  // Monitor: pops and compares whenever the DUT presents an event.
  initial begin
    permExp_t pe;
    sqExp_t   se;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1) begin
        if (perm_start === 1'b1) begin
          checkOutput("perm_start_expected", 320'(expPerm.size() != 0), 320'd1);
          if (expPerm.size() != 0) begin
            pe = expPerm.pop_front();
            checkOutput("perm_rounds", 320'(perm_rounds), 320'(pe.rounds));
            checkOutput("perm_in", perm_in, pe.din);
          end
        end
        if (sq_valid === 1'b1 && sq_ready === 1'b1) begin
          checkOutput("sq_expected", 320'(expSq.size() != 0), 320'd1);
          if (expSq.size() != 0) begin
            se = expSq.pop_front();
            checkOutput("sq_data", 320'(sq_data), 320'(se.data));
            checkOutput("sq_block_ctr", 320'(block_ctr), 320'(se.ctr));
          end
        end
        if (done === 1'b1) begin
          checkOutput("done_expected", 320'(expDone > 0), 320'd1);
          checkOutput("busy_in_done", 320'(busy), 320'd1);
          if (expDone > 0) expDone--;
        end
        if (perm_abort === 1'b1) begin
          checkOutput("perm_abort_expected", 320'(abortWindow), 320'd1);
        end
      end
    end
  end

  initial begin
    int n;
    logic [R-1:0] want;
    testsRun = 0;
    testsFailed = 0;
    expDone = 0;
    rst_n = 1'b0;
    start = 1'b0;
    mode = 1'b0;
    msg_blocks = '0;
    out_blocks = '0;
    abort = 1'b0;
    msg_valid = 1'b0;
    msg_data = '0;
    holdSqLow = 1'b0;
    echoMode = 1'b0;
    abortWindow = 1'b0;
`ifdef ASCON_SPONGE_EARLY_STOP_EN
    stopActive = 1'b0;
`endif

    repeat (3) @(negedge clk);
    #3;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // XOF, one block in, one block out, identity permutation.
    echoMode = 1'b1;
    applyStimulus(1'b1, 1, 1, 0);
    echoMode = 1'b0;

    // Three absorb permutations (B, B, A) then four squeeze words.
    applyStimulus(1'($urandom), 3, 4, 0);

    // Abort together with start in IDLE must not launch a job.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    msg_blocks = CW'(2);
    out_blocks = CW'(2);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #3;
    checkOutput("abort_start_state", 320'(state), 320'd0);
    checkOutput("abort_start_busy", 320'(busy), 320'd0);
    repeat (2) @(negedge clk);
    #3;
    checkOutput("abort_start_state_later", 320'(state), 320'd0);

    // Squeeze back-pressure: output must hold, no permutation may start.
    holdSqLow = 1'b1;
    fork
      applyStimulus(1'b0, 2, 2, 0);
      begin
        waitState(3'd4, "hold_reach_sq_out");
        want = (expSq.size() != 0) ? expSq[0].data : '0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          start = (i == 3);
          mode = 1'b1;
          #3;
          checkOutput("hold_sq_data", 320'(sq_data), 320'(want));
          checkOutput("hold_no_perm_start", 320'(perm_start), 320'd0);
          checkOutput("hold_state", 320'(state), 320'd4);
        end
        start = 1'b0;
        holdSqLow = 1'b0;
      end
    join

    // Abort during the second absorb permutation.
    begin
      logic [319:0] s;
      logic [R-1:0] md0, md1;
      permExp_t pe;
      md0 = R'({$urandom, $urandom});
      md1 = R'({$urandom, $urandom});
      s = IV_HASH_REF;
      s[319 -: R] = s[319 -: R] ^ md0;
      pe.rounds = 5'(B);
      pe.din = s;
      expPerm.push_back(pe);
      s = permModel(s, 5'(B));
      s[319 -: R] = s[319 -: R] ^ md1;
      pe.din = s;
      expPerm.push_back(pe);
      startJob(1'b0, 3, 2);
      feedMsg(md0);
      feedMsg(md1);
      #3;
      n = 0;
      while (!(state === 3'd3 && block_ctr === CW'(1)) && n < 400) begin
        @(negedge clk);
        #3;
        n++;
      end
      checkOutput("abort_reach_perm2", 320'(state), 320'd3);
      abortWindow = 1'b1;
      abort = 1'b1;
      #1;
      checkOutput("abort_perm_abort_pulse", 320'(perm_abort), 320'd1);
      @(negedge clk);
      abort = 1'b0;
      #3;
      checkOutput("abort_idle", 320'(state), 320'd0);
      checkOutput("abort_busy", 320'(busy), 320'd0);
      checkOutput("abort_block_ctr", 320'(block_ctr), 320'd0);
      checkOutput("abort_perm_abort_drop", 320'(perm_abort), 320'd0);
      abortWindow = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        #3;
        checkOutput("abort_stays_idle", 320'(state), 320'd0);
      end
      checkOutput("abort_perm_drained", 320'(expPerm.size()), 320'd0);
    end

    // Asynchronous reset in the middle of a squeeze permutation.
    buildJob(1'b1, 1, 3, 0);
    startJob(1'b1, 1, 3);
    feedMsg(jobMsgs[0]);
    waitState(3'd5, "rst_reach_sq_perm");
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midjob_reset");
    expPerm.delete();
    expSq.delete();
    expDone = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    applyStimulus(1'b0, 2, 2, 0);

    // Randomized jobs, including zero counts that behave as one.
    for (int j = 0; j < 10; j++) begin
      applyStimulus(1'($urandom), $urandom_range(0, 4), $urandom_range(0, 4), 0);
    end

`ifdef ASCON_SPONGE_EARLY_STOP_EN
    // Early stop on the fifth squeeze word of a 100-word request.
    applyStimulus(1'b1, 1, 100, 5);
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
